// File: rtl/gps_point_feeder.sv
// Point feeder for the GPS distance calculator: buffers host LON/LAT points, issues one
// per DEN paced to the calculator's accept windows, and returns each result with its index.
module gps_point_feeder #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned PTR_W     = 4,
    parameter int unsigned FIRST_GAP = 136,
    parameter int unsigned TIMEOUT   = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [23:0] wr_lon,
    input  logic [23:0] wr_lat,
    output logic        full,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        DEN,
    output logic [23:0] LON_IN,
    output logic [23:0] LAT_IN,
    input  logic        Valid,
    input  logic [39:0] D,
    input  logic [63:0] a,
    output logic        res_valid,
    output logic [39:0] res_D,
    output logic [63:0] res_a,
    output logic [15:0] res_idx
);

    localparam int unsigned CW    = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2((TIMEOUT > FIRST_GAP) ? TIMEOUT : FIRST_GAP) + 1;

    typedef enum logic [2:0] {IDLE, PRIME, GAP, SEND, WAITV} state_t;

    state_t             state, state_n;
    logic [47:0]        mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]      count, count_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               primed, primed_n;
    logic               push, pop, empty;
    logic               done_n, err_n, capture;

    assign empty   = (count == '0);
    assign push    = wr_en && !full;
    assign count_n = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

    // PRIME and SEND are the DEN cycles; the pop happens on entry so DEN/LON_IN/LAT_IN register together
    always_comb begin
        state_n  = state;
        cnt_n    = cnt + CNT_W'(1);
        primed_n = primed;
        done_n   = 1'b0;
        err_n    = err;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (start) begin
                    if (empty)        done_n  = 1'b1;
                    else if (!primed) state_n = PRIME;
                    else              state_n = SEND;
                end
            end
            PRIME: begin
                primed_n = 1'b1;
                cnt_n    = '0;
                state_n  = GAP;
            end
            GAP: begin
                if (cnt == CNT_W'(FIRST_GAP - 1)) begin
                    if (empty) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = SEND;
                    end
                end
            end
            SEND: begin
                cnt_n   = '0;
                state_n = WAITV;
            end
            WAITV: begin
                // Valid wins over a simultaneous timeout
                if (Valid) begin
                    capture = 1'b1;
                    if (empty) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = SEND;
                    end
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    err_n    = 1'b1;
                    primed_n = 1'b0;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        pop = (state_n == PRIME) || (state_n == SEND);
    end

    // Buffer storage; contents are don't-care once the pointers are reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {wr_lon, wr_lat};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            primed    <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            DEN       <= 1'b0;
            LON_IN    <= '0;
            LAT_IN    <= '0;
            res_valid <= 1'b0;
            res_D     <= '0;
            res_a     <= '0;
            res_idx   <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            primed    <= primed_n;
            count     <= count_n;
            full      <= (count_n == CW'(DEPTH));
            busy      <= (state_n != IDLE);
            done      <= done_n;
            err       <= err_n;
            DEN       <= pop;
            res_valid <= capture;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr           <= rd_ptr + PTR_W'(1);
                {LON_IN, LAT_IN} <= mem[rd_ptr];
            end
            if (capture) begin
                res_D <= D;
                res_a <= a;
            end
            if (res_valid) res_idx <= res_idx + 16'd1;
        end
    end

endmodule
